// File: rtl/sprite_mixer.sv
// N-sprite compositor for the 1024x768 VGA pipeline: frame-latched positions, index priority, colour key.
// Optional sticky overlap detector is built only when SPR_COLLIDE_EN is defined.
module sprite_mixer #(
  parameter int          N_SPR  = 4,
  parameter int          SPR_W  = 64,
  parameter int          SPR_H  = 64,
  parameter logic [11:0] TRANSP = 12'hF0F,
  localparam int         AW     = $clog2(SPR_W) + $clog2(SPR_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         hcount_in,
  input  logic [9:0]          vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [11:0]         rgb_in,
  input  logic [N_SPR*12-1:0] xpos_in,
  input  logic [N_SPR*12-1:0] ypos_in,
  input  logic [N_SPR-1:0]    spr_en,
  output logic [N_SPR*AW-1:0] rom_addr,
  input  logic [N_SPR*12-1:0] rom_data,
  output logic [10:0]         hcount_out,
  output logic [9:0]          vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [11:0]         rgb_out,
  output logic [N_SPR-1:0]    hit,
  output logic                collide
);
  localparam int LW = $clog2(SPR_W);
  localparam int LH = $clog2(SPR_H);

  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

  logic              vblnk_q;
  logic              frame_rise;
  logic [11:0]       sx [N_SPR];
  logic [11:0]       sy [N_SPR];
  logic [N_SPR-1:0]  en;

  assign frame_rise = vblnk_in & ~vblnk_q;

  // NOTE: the shadow arrays are a handful of flops, not a RAM, so resetting them is cheap and keeps sprites off after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      en      <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else begin
      vblnk_q <= vblnk_in;
      if (frame_rise) begin
        en <= spr_en;
        for (int i = 0; i < N_SPR; i++) begin
          sx[i] <= xpos_in[12*i +: 12];
          sy[i] <= ypos_in[12*i +: 12];
        end
      end
    end
  end

  // S1: window test in 13 bits so sx+SPR_W cannot wrap; address is the low bits of (pixel - origin).
  logic [N_SPR-1:0]    in_c;
  logic [N_SPR*AW-1:0] addr_c;

  // NOTE: every variable is given a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    in_c   = '0;
    addr_c = '0;
    for (int i = 0; i < N_SPR; i++) begin
      in_c[i] = en[i]
        && ({2'b00, hcount_in}  >= {1'b0, sx[i]})
        && ({2'b00, hcount_in}  <  {1'b0, sx[i]} + 13'(SPR_W))
        && ({3'b000, vcount_in} >= {1'b0, sy[i]})
        && ({3'b000, vcount_in} <  {1'b0, sy[i]} + 13'(SPR_H));
      if (in_c[i])
        addr_c[AW*i +: AW] = {vcount_in[LH-1:0] - sy[i][LH-1:0],
                              hcount_in[LW-1:0] - sx[i][LW-1:0]};
    end
  end

  logic [N_SPR-1:0] in1, in2;
  timing_t          d1, d2;
  logic [N_SPR-1:0] op;
  logic [11:0]      pix;
  logic             blank;

  // S3: key out transparent pixels, then the lowest opaque index wins.
  always_comb begin
    op  = in2;
    pix = d2.rgb;
    for (int i = 0; i < N_SPR; i++)
      if (rom_data[12*i +: 12] == TRANSP) op[i] = 1'b0;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (op[i]) pix = rom_data[12*i +: 12];
  end

  assign blank = d2.hblnk | d2.vblnk;

  // NOTE: pipeline state uses non-blocking assignments so each stage sees the previous stage's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr   <= '0;
      in1        <= '0;
      in2        <= '0;
      d1         <= '0;
      d2         <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      hit        <= '0;
    end else begin
      rom_addr   <= addr_c;
      in1        <= in_c;
      d1         <= '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
      in2        <= in1;
      d2         <= d1;
      hcount_out <= d2.hcount;
      vcount_out <= d2.vcount;
      hsync_out  <= d2.hsync;
      vsync_out  <= d2.vsync;
      hblnk_out  <= d2.hblnk;
      vblnk_out  <= d2.vblnk;
      rgb_out    <= blank ? 12'h000 : pix;
      hit        <= blank ? '0 : op;
    end
  end

`ifdef SPR_COLLIDE_EN
  // Two or more opaque bits on a visible pixel; the frame clear takes precedence.
  always_ff @(posedge clk) begin
    if (rst)
      collide <= 1'b0;
    else if (frame_rise)
      collide <= 1'b0;
    else if (!blank && ((op & (op - N_SPR'(1))) != '0))
      collide <= 1'b1;
  end
`else
  assign collide = 1'b0;
`endif

endmodule
